// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: decode-side issue, operand and forwarding-result bundle for fwd_scoreboard
interface fwd_scoreboard_if #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2
);
  logic                      issue_valid;
  logic                      issue_wr;
  logic                      issue_load;
  logic [REG_AW-1:0]         issue_dst;
  logic [NUM_SRC*REG_AW-1:0] src_idx;
  logic [NUM_SRC*DATA_W-1:0] src_rf_data;
  logic [DEPTH*DATA_W-1:0]   stage_data;
  logic                      stall_in;
  logic                      flush;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        fwd_hit;
  logic                      hazard_stall;
  logic [15:0]               stall_count;
  modport master (
    output issue_valid, issue_wr, issue_load, issue_dst, src_idx, src_rf_data,
           stage_data, stall_in, flush,
    input  src_data, fwd_hit, hazard_stall, stall_count
  );
  modport slave (
    input  issue_valid, issue_wr, issue_load, issue_dst, src_idx, src_rf_data,
           stage_data, stall_in, flush,
    output src_data, fwd_hit, hazard_stall, stall_count
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: shadow tag pipeline with youngest-producer forwarding and load-use interlock.
// FWD_BYPASS_EN defined gives full forwarding; undefined gives the interlock-only build.
module fwd_scoreboard #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2
) (
  input logic            clk,
  input logic            rst,
  fwd_scoreboard_if.slave bus
);
  logic [DEPTH-1:0]             vld;
  logic [DEPTH-1:0][REG_AW-1:0] dst;
  logic [NUM_SRC-1:0]           hz_s;
  logic                         hazard;
  logic                         accept;
  logic                         blk;
  logic [15:0]                  cnt;
`ifdef FWD_BYPASS_EN
  // only the load flag of entry 0 can ever block, so older flags are not kept
  logic                         ld0;
`endif
  always_comb begin
    bus.src_data = '0;
    bus.fwd_hit  = '0;
    hz_s         = '0;
    blk          = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      bus.src_data[s*DATA_W +: DATA_W] = bus.src_rf_data[s*DATA_W +: DATA_W];
      // walk oldest to youngest so the youngest match is the one that sticks
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (vld[k] && dst[k] == bus.src_idx[s*REG_AW +: REG_AW]) begin
`ifdef FWD_BYPASS_EN
          blk = (k == 0) && ld0;
`else
          blk = (k < DEPTH-1);
`endif
          bus.src_data[s*DATA_W +: DATA_W] = bus.stage_data[k*DATA_W +: DATA_W];
          bus.fwd_hit[s] = !blk;
          hz_s[s]        = blk;
        end
      end
    end
  end
  assign hazard           = bus.issue_valid && |hz_s;
  assign accept           = bus.issue_valid && bus.issue_wr && !hazard && !bus.flush && !bus.stall_in;
  assign bus.hazard_stall = hazard;
  assign bus.stall_count  = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      dst <= '0;
      cnt <= '0;
`ifdef FWD_BYPASS_EN
      ld0 <= 1'b0;
`endif
    end else if (!bus.stall_in) begin
      vld <= {vld[DEPTH-2:0], accept};
      dst <= {dst[DEPTH-2:0], bus.issue_dst};
`ifdef FWD_BYPASS_EN
      ld0 <= bus.issue_load;
`endif
      if (hazard && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed checks of forwarding, interlock, flush, stall and reset behaviour
module tb_fwd_scoreboard;
`ifdef FWD_BYPASS_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  fwd_scoreboard_if bus ();
  fwd_scoreboard dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic v, input logic w, input logic l, input logic [2:0] d);
    bus.issue_valid = v;
    bus.issue_wr    = w;
    bus.issue_load  = l;
    bus.issue_dst   = d;
  endtask
  task automatic srcs(input logic [2:0] a, input logic [2:0] b);
    bus.src_idx = {b, a};
  endtask
  initial begin
    issue(0, 0, 0, 0);
    srcs(0, 0);
    bus.stall_in    = 1'b0;
    bus.flush       = 1'b0;
    bus.src_rf_data = {16'h5678, 16'h1234};
    bus.stage_data  = {16'h0CCC, 16'h0BBB, 16'h00AA};
    repeat (2) tick;
    rst = 1'b0;
    // empty scoreboard: register file value passes through
    issue(1, 0, 0, 0);
    srcs(2, 0);
    #1;
    chk("reset_data", bus.src_data[15:0], 16'h1234);
    chk("reset_hit", bus.fwd_hit, 2'b00);
    chk("reset_haz", bus.hazard_stall, 1'b0);
    chk("reset_cnt", bus.stall_count, 16'd0);
    tick;
    issue(1, 1, 0, 3);
    srcs(1, 0);
    #1;
    chk("add_r3_haz", bus.hazard_stall, 1'b0);
    tick;
    // r3 at entry 0
    issue(1, 0, 0, 0);
    srcs(3, 0);
    #1;
    chk("e0_haz", bus.hazard_stall, FULL ? 1'b0 : 1'b1);
    chk("e0_hit", bus.fwd_hit, FULL ? 2'b01 : 2'b00);
    if (bus.fwd_hit[0]) chk("e0_data", bus.src_data[15:0], 16'h00AA);
    tick;
    // r3 at entry 1
    bus.stage_data = {16'h0CCC, 16'h00AA, 16'h0111};
    #1;
    chk("e1_haz", bus.hazard_stall, FULL ? 1'b0 : 1'b1);
    chk("e1_hit", bus.fwd_hit, FULL ? 2'b01 : 2'b00);
    if (bus.fwd_hit[0]) chk("e1_data", bus.src_data[15:0], 16'h00AA);
    tick;
    // r3 at writeback forwards in both builds
    #1;
    chk("e2_haz", bus.hazard_stall, 1'b0);
    chk("e2_hit", bus.fwd_hit, 2'b01);
    chk("e2_data", bus.src_data[15:0], 16'h0CCC);
    chk("e2_cnt", bus.stall_count, FULL ? 16'd0 : 16'd2);
    tick;
    // r3 in entries 0 and 2, r6 in entry 1
    issue(1, 1, 0, 3);
    srcs(1, 0);
    tick;
    issue(1, 1, 0, 6);
    tick;
    issue(1, 1, 0, 3);
    tick;
    issue(0, 0, 0, 0);
    srcs(3, 6);
    bus.stage_data = {16'h3333, 16'h2222, 16'h1111};
    #1;
    chk("young_haz_invalid", bus.hazard_stall, 1'b0);
    chk("young_hit", bus.fwd_hit, FULL ? 2'b11 : 2'b00);
    if (bus.fwd_hit[0]) chk("young_data0", bus.src_data[15:0], 16'h1111);
    if (bus.fwd_hit[1]) chk("young_data1", bus.src_data[31:16], 16'h2222);
    repeat (3) tick;
    // load-use
    issue(1, 1, 1, 5);
    srcs(1, 0);
    #1;
    chk("ld_haz", bus.hazard_stall, 1'b0);
    tick;
    issue(1, 1, 0, 7);
    srcs(5, 0);
    bus.stage_data = {16'h0CCC, 16'h5555, 16'h00AA};
    #1;
    chk("use_haz", bus.hazard_stall, 1'b1);
    tick;
    chk("use2_haz", bus.hazard_stall, FULL ? 1'b0 : 1'b1);
    chk("use2_hit", bus.fwd_hit, FULL ? 2'b01 : 2'b00);
    if (bus.fwd_hit[0]) chk("use2_data", bus.src_data[15:0], 16'h5555);
    tick;
    bus.stage_data = {16'h7777, 16'h5555, 16'h00AA};
    #1;
    chk("use3_haz", bus.hazard_stall, 1'b0);
    chk("use3_hit", bus.fwd_hit, 2'b01);
    chk("use3_data", bus.src_data[15:0], 16'h7777);
    tick;
    chk("ld_cnt", bus.stall_count, FULL ? 16'd1 : 16'd4);
    issue(0, 0, 0, 0);
    repeat (3) tick;
    // flush squashes the issue, older r2 still shifts
    issue(1, 1, 0, 2);
    srcs(1, 0);
    tick;
    issue(1, 1, 0, 4);
    bus.flush = 1'b1;
    #1;
    chk("flush_haz", bus.hazard_stall, 1'b0);
    tick;
    bus.flush = 1'b0;
    issue(0, 0, 0, 0);
    srcs(4, 2);
    bus.stage_data = {16'h0CCC, 16'h2222, 16'h00AA};
    #1;
    chk("flush_hit", bus.fwd_hit, FULL ? 2'b10 : 2'b00);
    chk("flush_data0", bus.src_data[15:0], 16'h1234);
    if (bus.fwd_hit[1]) chk("flush_data1", bus.src_data[31:16], 16'h2222);
    // external stall freezes entries and the counter
    bus.stall_in = 1'b1;
    issue(1, 1, 0, 1);
    srcs(2, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_haz", bus.hazard_stall, FULL ? 1'b0 : 1'b1);
      chk("stall_hit", bus.fwd_hit, FULL ? 2'b01 : 2'b00);
      chk("stall_cnt", bus.stall_count, FULL ? 16'd1 : 16'd4);
      tick;
    end
    bus.stall_in = 1'b0;
    issue(0, 0, 0, 0);
    #1;
    chk("frozen_hit", bus.fwd_hit, FULL ? 2'b01 : 2'b00);
    chk("frozen_cnt", bus.stall_count, FULL ? 16'd1 : 16'd4);
    // reset wins over stall_in
    rst = 1'b1;
    bus.stall_in = 1'b1;
    tick;
    rst = 1'b0;
    bus.stall_in = 1'b0;
    issue(1, 0, 0, 0);
    #1;
    chk("rst2_hit", bus.fwd_hit, 2'b00);
    chk("rst2_data", bus.src_data[15:0], 16'h1234);
    chk("rst2_haz", bus.hazard_stall, 1'b0);
    chk("rst2_cnt", bus.stall_count, 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
